countdown_arbiter: RTL and testbench

- Shares one N-bit countdown timer among NREQ requesters.
- Round-robin arbiter grants the timer to one requester at a time.
- Loads that requester's start value and decrements it to zero once per clock.
- Pulses that requester's done bit, then returns to arbitration. Sits in front of the countdown datapath as its sequencer.

---
 rtl/countdown_arbiter.sv | 117 +++++++++++
 tb/tb_countdown_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_arbiter.sv
// Round-robin sequencer sharing one countdown timer among NREQ requesters.
// Optional macro COUNTDOWN_PAUSE_EN adds a pause input that freezes the count in RUN.
module countdown_arbiter #(
   parameter int N    = 8,
   parameter int NREQ = 4
) (
   input  logic                 clk,
   input  logic                 rst_async,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*N-1:0]    init_number,
`ifdef COUNTDOWN_PAUSE_EN
   input  logic                 pause,
`endif
   output logic [NREQ-1:0]      grant,
   output logic [N-1:0]         count,
   output logic                 busy,
   output logic [NREQ-1:0]      done
);

   localparam int IW = $clog2(NREQ);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, state_nx;
   logic [IW-1:0]     last, last_nx;
   logic [NREQ-1:0]   grant_nx;
   logic [N-1:0]      count_nx;
   logic [N-1:0]      slice [NREQ];
   logic [IW-1:0]     sel, cand;
   logic              found;
   logic              hold;

   for (genvar g = 0; g < NREQ; g++) begin : g_slice
      assign slice[g] = init_number[g*N +: N];
   end

`ifdef COUNTDOWN_PAUSE_EN
   assign hold = pause;
`else
   assign hold = 1'b0;
`endif

   // Scan starts just past the previous owner, so the last winner has lowest priority.
   always_comb begin
      sel   = '0;
      cand  = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         cand = IW'((32'(last) + 32'd1 + i) % 32'(NREQ));
         if (!found && req[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   // last doubles as the owner index while a tenure is in progress.
   always_comb begin
      state_nx = state;
      grant_nx = grant;
      count_nx = count;
      last_nx  = last;
      case (state)
         IDLE: begin
            grant_nx = '0;
            count_nx = '0;
            if (found) begin
               state_nx      = RUN;
               grant_nx[sel] = 1'b1;
               last_nx       = sel;
               count_nx      = slice[sel];
            end
         end
         RUN: begin
            if (!req[last]) begin
               state_nx = IDLE;
               grant_nx = '0;
               count_nx = '0;
            end else if (hold) begin
               count_nx = count;
            end else if (count == '0) begin
               state_nx = DONE;
            end else begin
               count_nx = count - N'(1);
            end
         end
         DONE: begin
            state_nx = IDLE;
            grant_nx = '0;
            count_nx = '0;
         end
         default: begin
            state_nx = IDLE;
            grant_nx = '0;
            count_nx = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_async) begin
      if (!rst_async) begin
         state <= IDLE;
         grant <= '0;
         count <= '0;
         last  <= IW'(NREQ - 1);
      end else begin
         state <= state_nx;
         grant <= grant_nx;
         count <= count_nx;
         last  <= last_nx;
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE) ? grant : '0;

endmodule

// File: tb/tb_countdown_arbiter.sv
// Scoreboard bench for countdown_arbiter: directed stimulus queues expected grant/done/abort events.
// Define COUNTDOWN_PAUSE_EN to also exercise the pause input.
module tb_countdown_arbiter;

   localparam int K_GRANT = 0;
   localparam int K_DONE  = 1;
   localparam int K_ABORT = 2;

   typedef struct {
      int         kind;
      logic [3:0] vec;
      logic [7:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_async = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] init_number = '0;
`ifdef COUNTDOWN_PAUSE_EN
   logic        pause = 1'b0;
`endif
   logic [3:0]  grant;
   logic [7:0]  count;
   logic        busy;
   logic [3:0]  done;

   exp_t        q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [3:0]  prev_grant, prev_done;

   countdown_arbiter #(.N(8), .NREQ(4)) dut (
      .clk         (clk),
      .rst_async   (rst_async),
      .req         (req),
      .init_number (init_number),
`ifdef COUNTDOWN_PAUSE_EN
      .pause       (pause),
`endif
      .grant       (grant),
      .count       (count),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int kind, input logic [3:0] vec, input logic [7:0] cnt);
      exp_t e;
      e.kind = kind;
      e.vec  = vec;
      e.cnt  = cnt;
      q.push_back(e);
   endtask

   task automatic set_slice(input int idx, input logic [7:0] v);
      init_number[idx*8 +: 8] = v;
   endtask

   task automatic chk_idle(input string name);
      chk({name, "_grant"}, 32'(grant), 32'h0);
      chk({name, "_count"}, 32'(count), 32'h0);
      chk({name, "_busy"},  32'(busy),  32'h0);
      chk({name, "_done"},  32'(done),  32'h0);
   endtask

   task automatic check_event(input int kind);
      exp_t e;
      if (q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL unexpected_event: got kind %0d grant %0h done %0h expected none", kind, grant, done);
      end else begin
         e = q.pop_front();
         chk("ev_kind", 32'(kind), 32'(e.kind));
         case (kind)
            K_GRANT: begin
               chk("ev_grant", 32'(grant), 32'(e.vec));
               chk("ev_start", 32'(count), 32'(e.cnt));
            end
            K_DONE: begin
               chk("ev_done",       32'(done),  32'(e.vec));
               chk("ev_done_grant", 32'(grant), 32'(e.vec));
               chk("ev_done_count", 32'(count), 32'h0);
            end
            default: begin
               chk("ev_abort_count", 32'(count), 32'h0);
               chk("ev_abort_busy",  32'(busy),  32'h0);
            end
         endcase
      end
   endtask

   // Monitor: one event per grant start, done pulse, or grant drop without done.
   initial begin
      prev_grant = '0;
      prev_done  = '0;
      forever begin
         @(negedge clk);
         if (!rst_async) begin
            prev_grant = '0;
            prev_done  = '0;
         end else begin
            if (done != '0) check_event(K_DONE);
            if (grant != '0 && prev_grant == '0) check_event(K_GRANT);
            if (grant == '0 && prev_grant != '0 && prev_done == '0) check_event(K_ABORT);
            prev_grant = grant;
            prev_done  = done;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held with all requests high
      req         = 4'b1111;
      init_number = {4{8'd3}};
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_idle("reset");
      end
      push(K_GRANT, 4'b0001, 8'd3);
      rst_async = 1'b1;
      tick();
      chk("first_grant", 32'(grant), 32'h1);
      chk("first_count", 32'(count), 32'h3);
      req = 4'b0000;
      push(K_ABORT, 4'b0001, 8'd0);
      tick();
      chk_idle("first_abort");

      // Single countdown from 6 (pointer now at 0, requester 0 wins again)
      set_slice(0, 8'd6);
      req = 4'b0001;
      push(K_GRANT, 4'b0001, 8'd6);
      push(K_DONE,  4'b0001, 8'd0);
      tick();
      chk("single_grant", 32'(grant), 32'h1);
      chk("single_count", 32'(count), 32'h6);
      chk("single_busy",  32'(busy),  32'h1);
      for (int k = 5; k >= 0; k--) begin
         tick();
         chk("single_dec", 32'(count), 32'(k));
         chk("single_nodone", 32'(done), 32'h0);
      end
      tick();
      chk("single_done", 32'(done), 32'h1);
      chk("single_done_grant", 32'(grant), 32'h1);
      req = 4'b0000;
      tick();
      chk_idle("single_end");

      // Round robin: restart pointer, every slice = 2, five-cycle tenures
      rst_async = 1'b0;
      tick();
      rst_async = 1'b1;
      init_number = {4{8'd2}};
      req = 4'b1111;
      push(K_GRANT, 4'b0001, 8'd2); push(K_DONE, 4'b0001, 8'd0);
      push(K_GRANT, 4'b0010, 8'd2); push(K_DONE, 4'b0010, 8'd0);
      push(K_GRANT, 4'b0100, 8'd2); push(K_DONE, 4'b0100, 8'd0);
      push(K_GRANT, 4'b1000, 8'd2); push(K_DONE, 4'b1000, 8'd0);
      push(K_GRANT, 4'b0001, 8'd2); push(K_DONE, 4'b0001, 8'd0);
      for (int t = 1; t <= 25; t++) begin
         tick();
         if (t == 1)  chk("rr_g0", 32'(grant), 32'h1);
         if (t == 6)  chk("rr_g1", 32'(grant), 32'h2);
         if (t == 11) chk("rr_g2", 32'(grant), 32'h4);
         if (t == 16) chk("rr_g3", 32'(grant), 32'h8);
         if (t == 19) chk("rr_done3", 32'(done), 32'h8);
         if (t == 20) chk("rr_gap", 32'(grant), 32'h0);
         if (t == 21) begin
            chk("rr_g4", 32'(grant), 32'h1);
            req = 4'b0001;
         end
         if (t == 24) req = 4'b0000;
      end
      chk_idle("rr_end");

      // Abort at count 3 (pointer at 0)
      set_slice(0, 8'd9);
      req = 4'b0001;
      push(K_GRANT, 4'b0001, 8'd9);
      push(K_ABORT, 4'b0001, 8'd0);
      tick();
      chk("abort_start", 32'(count), 32'h9);
      for (int i = 0; i < 6; i++) tick();
      chk("abort_at3", 32'(count), 32'h3);
      req = 4'b0000;
      tick();
      chk_idle("abort");
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("abort_nodone", 32'(done), 32'h0);
      end

      // Zero load with req[2] contending
      set_slice(1, 8'd0);
      set_slice(2, 8'd1);
      req = 4'b0110;
      push(K_GRANT, 4'b0010, 8'd0); push(K_DONE, 4'b0010, 8'd0);
      push(K_GRANT, 4'b0100, 8'd1); push(K_DONE, 4'b0100, 8'd0);
      for (int t = 1; t <= 7; t++) begin
         tick();
         if (t == 1) begin
            chk("zero_grant", 32'(grant), 32'h2);
            chk("zero_count", 32'(count), 32'h0);
         end
         if (t == 2) chk("zero_done", 32'(done), 32'h2);
         if (t == 4) begin
            chk("contend_grant", 32'(grant), 32'h4);
            chk("contend_count", 32'(count), 32'h1);
            req = 4'b0100;
         end
         if (t == 6) begin
            chk("contend_done", 32'(done), 32'h4);
            req = 4'b0000;
         end
      end
      chk_idle("zero_end");

      // Asynchronous reset mid-run
      set_slice(0, 8'd6);
      req = 4'b0001;
      push(K_GRANT, 4'b0001, 8'd6);
      for (int i = 0; i < 3; i++) tick();
      chk("midrun_count", 32'(count), 32'h4);
      #2;
      rst_async = 1'b0;
      #1;
      chk_idle("async_reset");
      req = 4'b0100;
      tick();
      rst_async = 1'b1;
      push(K_GRANT, 4'b0100, 8'd1);
      tick();
      chk("post_reset_grant", 32'(grant), 32'h4);
      req = 4'b0000;
      push(K_ABORT, 4'b0100, 8'd0);
      tick();
      chk_idle("post_reset_abort");

`ifdef COUNTDOWN_PAUSE_EN
      // Pause for three cycles at count 3 delays done by three cycles
      set_slice(0, 8'd5);
      req = 4'b0001;
      push(K_GRANT, 4'b0001, 8'd5);
      push(K_DONE,  4'b0001, 8'd0);
      for (int t = 1; t <= 11; t++) begin
         tick();
         if (t == 3) begin
            chk("pause_at3", 32'(count), 32'h3);
            pause = 1'b1;
         end
         if (t >= 4 && t <= 6) chk("pause_hold", 32'(count), 32'h3);
         if (t == 6) pause = 1'b0;
         if (t == 7) chk("pause_resume", 32'(count), 32'h2);
         if (t == 9) chk("pause_zero", 32'(count), 32'h0);
         if (t == 10) begin
            chk("pause_done", 32'(done), 32'h1);
            req = 4'b0000;
         end
      end
      chk_idle("pause_end");
`endif

      for (int i = 0; i < 20 && q.size() != 0; i++) tick();
      chk("queue_drained", 32'(q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
